// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the byte-lane data memory load/store unit:
// RV32I funct3 encodings, FSM states and lane-mask helpers.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_CAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Byte-lane mask over two consecutive words; bits [7:4] belong to the HI word.
    function automatic logic [7:0] lane_mask(input logic [1:0] size_code, input logic [1:0] off);
        logic [7:0] base;
        case (size_code)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
        logic bad;
        case (funct3)
            3'b000, 3'b001, 3'b010: bad = 1'b0;
            3'b100, 3'b101:         bad = we;
            default:                bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake plus the shared byte-lane memory bus of the LSU.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Environment side: core issuing requests and the lane memories answering reads.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dmem_lsu_load_align.sv
// Load result alignment: shifts the captured (possibly two-word) data down by
// the byte offset and sign/zero-extends it according to funct3.
module dmem_load_align
    import dmem_lsu_pkg::*;
(
    input  logic [63:0] data64,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted_s;

    assign shifted_s = 32'(data64 >> {off, 3'b000});

    // Truncate to the access size and extend.
    always_comb begin
        result = 32'h0000_0000;
        case (funct3)
            F3_LB:   result = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_LH:   result = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_LW:   result = shifted_s;
            F3_LBU:  result = {24'h00_0000, shifted_s[7:0]};
            F3_LHU:  result = {16'h0000, shifted_s[15:0]};
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving four 8-bit dmem lanes; accesses crossing a word
// boundary are split into LO and HI aligned word accesses.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_lsu_if.slave  bus
);

    state_t      state_r;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic        split_r;
    logic [3:0]  mask_hi_r;
    logic [31:0] wdata_hi_r;
    logic [31:0] hi_addr_r;
    logic [31:0] lo_buf_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;
    logic [31:0] mem_addr_r;
    logic [3:0]  mem_we_r;
    logic [31:0] mem_wdata_r;

    logic [7:0]  req_mask_s;
    logic        req_split_s;
    logic        req_bad_s;
    logic [63:0] req_wdata64_s;
    logic [31:0] req_lo_addr_s;
    logic [63:0] data64_s;
    logic [31:0] load_result_s;

    assign req_mask_s    = lane_mask(bus.req_funct3[1:0], bus.req_addr[1:0]);
    assign req_split_s   = |req_mask_s[7:4];
    assign req_bad_s     = funct3_illegal(bus.req_we, bus.req_funct3) ||
                           (req_split_s && !ALLOW_MISALIGNED);
    assign req_wdata64_s = {32'h0000_0000, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
    assign req_lo_addr_s = {bus.req_addr[31:2], 2'b00};

    // For split loads the LO word was parked in lo_buf while HI was being read.
    assign data64_s = split_r ? {bus.mem_rdata, lo_buf_r} : {32'h0000_0000, bus.mem_rdata};

    dmem_load_align u_align (
        .data64 (data64_s),
        .off    (off_r),
        .funct3 (funct3_r),
        .result (load_result_s)
    );

    assign bus.req_ready  = (state_r == ST_IDLE);
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_wdata  = mem_wdata_r;

    // Request FSM; memory-side outputs are registered on entry to LO/HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            we_r         <= 1'b0;
            funct3_r     <= 3'b000;
            off_r        <= 2'b00;
            split_r      <= 1'b0;
            mask_hi_r    <= 4'b0000;
            wdata_hi_r   <= 32'h0000_0000;
            hi_addr_r    <= 32'h0000_0000;
            lo_buf_r     <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            mem_addr_r   <= 32'h0000_0000;
            mem_we_r     <= 4'b0000;
            mem_wdata_r  <= 32'h0000_0000;
        end else begin
            resp_valid_r <= 1'b0;
            mem_we_r     <= 4'b0000;
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_r       <= bus.req_we;
                        funct3_r   <= bus.req_funct3;
                        off_r      <= bus.req_addr[1:0];
                        split_r    <= req_split_s;
                        mask_hi_r  <= req_mask_s[7:4];
                        wdata_hi_r <= req_wdata64_s[63:32];
                        hi_addr_r  <= req_lo_addr_s + 32'd4;
                        if (req_bad_s) begin
                            state_r      <= ST_DONE;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                        end else begin
                            state_r     <= ST_LO;
                            mem_addr_r  <= req_lo_addr_s;
                            mem_we_r    <= req_mask_s[3:0] & {4{bus.req_we}};
                            mem_wdata_r <= req_wdata64_s[31:0];
                        end
                    end
                end
                ST_LO: begin
                    if (split_r) begin
                        state_r     <= ST_HI;
                        mem_addr_r  <= hi_addr_r;
                        mem_we_r    <= mask_hi_r & {4{we_r}};
                        mem_wdata_r <= wdata_hi_r;
                    end else if (!we_r) begin
                        state_r <= ST_CAP;
                    end else begin
                        state_r      <= ST_DONE;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'h0000_0000;
                    end
                end
                ST_HI: begin
                    if (!we_r) begin
                        lo_buf_r <= bus.mem_rdata;
                        state_r  <= ST_CAP;
                    end else begin
                        state_r      <= ST_DONE;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'h0000_0000;
                    end
                end
                ST_CAP: begin
                    state_r      <= ST_DONE;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= load_result_s;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: two instances (misaligned allowed / rejected)
// share the request stream and are checked against a byte-array reference model.
module tb_dmem_lsu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if bus0 ();
    dmem_lsu_if bus1 ();

    dmem_lsu #(.ALLOW_MISALIGNED(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    dmem_lsu #(.ALLOW_MISALIGNED(1'b0)) u_dut_strict (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    assign bus1.req_valid  = bus0.req_valid;
    assign bus1.req_we     = bus0.req_we;
    assign bus1.req_funct3 = bus0.req_funct3;
    assign bus1.req_addr   = bus0.req_addr;
    assign bus1.req_wdata  = bus0.req_wdata;
    assign bus1.mem_rdata  = 32'h0000_0000;

    bit [7:0] dut_mem [1024];
    bit [7:0] ref_mem [1024];

    int total = 0;
    int bad   = 0;

    logic [31:0] tr_addr  [4];
    logic [3:0]  tr_we    [4];
    logic [31:0] tr_wdata [4];
    int          lat0, lat1;
    logic [31:0] rd0, rd1;
    logic        err0, err1;
    logic [3:0]  wor0, wor1;

    // Lane memory for the main instance: synchronous read, byte-enable write.
    always @(posedge clk) begin
        bus0.mem_rdata <= {dut_mem[{bus0.mem_addr[9:2], 2'd3}], dut_mem[{bus0.mem_addr[9:2], 2'd2}],
                           dut_mem[{bus0.mem_addr[9:2], 2'd1}], dut_mem[{bus0.mem_addr[9:2], 2'd0}]};
        for (int i = 0; i < 4; i++)
            if (bus0.mem_we[i]) dut_mem[{bus0.mem_addr[9:2], 2'(i)}] <= bus0.mem_wdata[8*i +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nbytes(f3); i++) v[8*i +: 8] = ref_mem[10'(a + 32'(i))];
        if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        for (int i = 0; i < nbytes(f3); i++) ref_mem[10'(a + 32'(i))] = wd[8*i +: 8];
    endtask

    function automatic int mem_diff();
        int d = 0;
        for (int i = 0; i < 1024; i++) if (dut_mem[i] != ref_mem[i]) d++;
        return d;
    endfunction

    // One request through both instances; records per-cycle bus traces and responses.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        chk("ready", 32'(bus0.req_ready), 32'd1);
        chk("pulse_low", 32'(bus0.resp_valid), 32'd0);
        bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_funct3 = f3;
        bus0.req_addr = addr; bus0.req_wdata = wd;
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0; bus0.req_we = 1'($urandom); bus0.req_funct3 = 3'($urandom);
        bus0.req_addr = $urandom; bus0.req_wdata = $urandom;
        lat0 = 0; lat1 = 0; wor0 = 4'b0; wor1 = 4'b0;
        rd0 = 32'hx; rd1 = 32'hx; err0 = 1'bx; err1 = 1'bx;
        for (int c = 1; c <= 12 && (lat0 == 0 || lat1 == 0); c++) begin
            @(negedge clk);
            if (c <= 4) begin
                tr_addr[c-1] = bus0.mem_addr; tr_we[c-1] = bus0.mem_we; tr_wdata[c-1] = bus0.mem_wdata;
            end
            wor0 |= bus0.mem_we;
            wor1 |= bus1.mem_we;
            if (lat0 == 0 && bus0.resp_valid) begin lat0 = c; rd0 = bus0.resp_rdata; err0 = bus0.resp_err; end
            if (lat1 == 0 && bus1.resp_valid) begin lat1 = c; rd1 = bus1.resp_rdata; err1 = bus1.resp_err; end
        end
    endtask

    // Drives one request and checks it against the reference rules.
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        logic ill, split, e0, e1;
        int l0, l1;
        logic [31:0] exp_rd;
        ill = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                (!we && (f3 == 3'b100 || f3 == 3'b101)));
        split = (int'(addr[1:0]) + nbytes(f3)) > 4;
        e0 = ill;
        e1 = ill || split;
        l0 = e0 ? 1 : (split ? (we ? 3 : 4) : (we ? 2 : 3));
        l1 = e1 ? 1 : l0;
        exp_rd = 32'h0;
        if (!e0 && !we) exp_rd = ref_load(addr, f3);
        if (!e0 && we) ref_store(addr, f3, wd);
        xact(we, f3, addr, wd);
        chk("lat", 32'(lat0), 32'(l0));
        chk("err", 32'(err0), 32'(e0));
        chk("rdata", rd0, exp_rd);
        chk("strict_lat", 32'(lat1), 32'(l1));
        chk("strict_err", 32'(err1), 32'(e1));
        chk("strict_rdata", rd1, 32'h0);
        chk("mem_image", 32'(mem_diff()), 32'd0);
        if (e0 || !we) chk("no_write", 32'(wor0), 32'd0);
        if (e1) chk("strict_no_write", 32'(wor1), 32'd0);
    endtask

    initial begin
        logic        we_v;
        logic [2:0]  f3_v;
        logic [31:0] a_v;
        int          k;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = 3'b000;
        bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(bus0.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus0.resp_rdata, 32'h0);
        chk("rst_mem_we", 32'(bus0.mem_we), 32'd0);
        chk("rst_mem_addr", bus0.mem_addr, 32'h0);
        chk("rst_ready", 32'(bus0.req_ready), 32'd1);
        rst_n = 1'b1;

        run(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        chk("sw_addr", tr_addr[0], 32'h100);
        chk("sw_we", 32'(tr_we[0]), 32'hF);
        chk("sw_wdata", tr_wdata[0], 32'hDEADBEEF);
        chk("sw_lat", 32'(lat0), 32'd2);

        run(1'b1, 3'b000, 32'h103, 32'h0000_0080);
        run(1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb_we", 32'(tr_we[0]), 32'h0);
        chk("lb_data", rd0, 32'hFFFFFF80);
        chk("lb_lat", 32'(lat0), 32'd3);
        run(1'b0, 3'b100, 32'h103, 32'h0);
        chk("lbu_data", rd0, 32'h0000_0080);

        run(1'b1, 3'b001, 32'h0FF, 32'h0000_A1B2);
        chk("sh_lo_addr", tr_addr[0], 32'h0FC);
        chk("sh_lo_we", 32'(tr_we[0]), 32'h8);
        chk("sh_lo_byte", 32'(tr_wdata[0][31:24]), 32'hB2);
        chk("sh_hi_addr", tr_addr[1], 32'h100);
        chk("sh_hi_we", 32'(tr_we[1]), 32'h1);
        chk("sh_hi_byte", 32'(tr_wdata[1][7:0]), 32'hA1);
        chk("sh_strict_err", 32'(err1), 32'd1);
        run(1'b0, 3'b101, 32'h0FF, 32'h0);
        chk("lhu_split_data", rd0, 32'h0000_A1B2);
        chk("lhu_split_lat", 32'(lat0), 32'd4);

        run(1'b0, 3'b011, 32'h104, 32'h0);
        chk("bad_f3_err", 32'(err0), 32'd1);
        chk("bad_f3_rdata", rd0, 32'h0);

        run(1'b1, 3'b010, 32'hFFFFFFFC, 32'h11223344);
        run(1'b1, 3'b010, 32'h0000_0000, 32'h55667788);
        run(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
        chk("wrap_lo_addr", tr_addr[0], 32'hFFFFFFFC);
        chk("wrap_hi_addr", tr_addr[1], 32'h0);
        chk("wrap_data", rd0, 32'h77881122);

        // Reset lands while the HI half of a split store is on the bus.
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_funct3 = 3'b001;
        bus0.req_addr = 32'h0FF; bus0.req_wdata = 32'h0000_5566;
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mem_we", 32'(bus0.mem_we), 32'd0);
        chk("abort_mem_addr", bus0.mem_addr, 32'h0);
        chk("abort_mem_wdata", bus0.mem_wdata, 32'h0);
        chk("abort_resp_rdata", bus0.resp_rdata, 32'h0);
        chk("abort_ready", 32'(bus0.req_ready), 32'd1);
        ref_mem[10'h0FF] = 8'h66;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_mem_image", 32'(mem_diff()), 32'd0);

        for (int n = 0; n < 150; n++) begin
            we_v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3_v = 3'($urandom);
            else if (we_v) f3_v = 3'($urandom_range(0, 2));
            else begin
                k = $urandom_range(0, 4);
                f3_v = (k < 3) ? 3'(k) : 3'(k + 1);
            end
            if ($urandom_range(0, 7) == 0) a_v = 32'hFFFFFFFC + 32'($urandom_range(0, 7));
            else a_v = 32'h0F0 + 32'($urandom_range(0, 31));
            run(we_v, f3_v, a_v, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
